// File: rtl/dp_arbiter.sv
// rtl/dp_arbiter.sv - two-port arbiter sharing the ALU/register-file control bundle
module dp_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HCW      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] const0,
    input  logic [7:0] const1,
    input  logic [2:0] inmux0,
    input  logic [2:0] inmux1,
    input  logic [3:0] outmux0,
    input  logic [3:0] outmux1,
    input  logic [3:0] regadd0,
    input  logic [3:0] regadd1,
    input  logic       we0,
    input  logic       we1,
    input  logic [1:0] inssel0,
    input  logic [1:0] inssel1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] CUconst,
    output logic [2:0] InMuxAdd,
    output logic [3:0] OutMuxAdd,
    output logic [3:0] RegAdd,
    output logic       WE,
    output logic [1:0] InsSel,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Last cycle of a grant's allowance when the other port is waiting.
    localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD - 1);

    state_t         state;
    logic           last;
    logic [HCW-1:0] hold;

    // Arbitration FSM: grant selection, fairness memory and hold counter.
    // The hold counter stops at HOLD_LIM while the other port is quiet, so a
    // late request from the other side is served at the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            last  <= 1'b1;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= GNT0;
                        gnt0  <= 1'b1;
                        gnt1  <= 1'b0;
                        last  <= 1'b0;
                        hold  <= '0;
                    end else if (req1) begin
                        state <= GNT1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b1;
                        last  <= 1'b1;
                        hold  <= '0;
                    end
                end
                GNT0: begin
                    if (!req0 || (req1 && hold == HOLD_LIM)) begin
                        if (req1) begin
                            state <= GNT1;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b1;
                            last  <= 1'b1;
                            hold  <= '0;
                        end else begin
                            state <= IDLE;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                        end
                    end else if (hold != HOLD_LIM) begin
                        hold <= hold + 1'b1;
                    end
                end
                GNT1: begin
                    if (!req1 || (req0 && hold == HOLD_LIM)) begin
                        if (req0) begin
                            state <= GNT0;
                            gnt0  <= 1'b1;
                            gnt1  <= 1'b0;
                            last  <= 1'b0;
                            hold  <= '0;
                        end else begin
                            state <= IDLE;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                        end
                    end else if (hold != HOLD_LIM) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath bundle mux; the write enable also needs the owner's live request.
    always_comb begin
        CUconst   = '0;
        InMuxAdd  = '0;
        OutMuxAdd = '0;
        RegAdd    = '0;
        WE        = 1'b0;
        InsSel    = '0;
        case (state)
            GNT0: begin
                CUconst   = const0;
                InMuxAdd  = inmux0;
                OutMuxAdd = outmux0;
                RegAdd    = regadd0;
                WE        = we0 & req0;
                InsSel    = inssel0;
            end
            GNT1: begin
                CUconst   = const1;
                InMuxAdd  = inmux1;
                OutMuxAdd = outmux1;
                RegAdd    = regadd1;
                WE        = we1 & req1;
                InsSel    = inssel1;
            end
            default: ;
        endcase
    end

    assign Busy = gnt0 | gnt1;

endmodule

// File: tb/tb_dp_arbiter.sv
// tb/tb_dp_arbiter.sv - directed self-checking bench for dp_arbiter
module tb_dp_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] const0, const1;
    logic [2:0] inmux0, inmux1;
    logic [3:0] outmux0, outmux1;
    logic [3:0] regadd0, regadd1;
    logic       we0, we1;
    logic [1:0] inssel0, inssel1;
    logic       gnt0, gnt1;
    logic [7:0] CUconst;
    logic [2:0] InMuxAdd;
    logic [3:0] OutMuxAdd;
    logic [3:0] RegAdd;
    logic       WE;
    logic [1:0] InsSel;
    logic       Busy;

    int errors = 0;
    int checks = 0;

    dp_arbiter #(.MAX_HOLD(4), .HCW(5)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .const0(const0), .const1(const1),
        .inmux0(inmux0), .inmux1(inmux1),
        .outmux0(outmux0), .outmux1(outmux1),
        .regadd0(regadd0), .regadd1(regadd1),
        .we0(we0), .we1(we1),
        .inssel0(inssel0), .inssel1(inssel1),
        .gnt0(gnt0), .gnt1(gnt1),
        .CUconst(CUconst), .InMuxAdd(InMuxAdd), .OutMuxAdd(OutMuxAdd),
        .RegAdd(RegAdd), .WE(WE), .InsSel(InsSel), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0;
        const0 = 0; const1 = 0; inmux0 = 0; inmux1 = 0;
        outmux0 = 0; outmux1 = 0; regadd0 = 0; regadd1 = 0;
        we0 = 0; we1 = 0; inssel0 = 0; inssel1 = 0;
        step();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_const", CUconst, 0);

        // single request from port 0, then release
        reset = 0; req0 = 1; const0 = 8'hA5; regadd0 = 4'h3; inssel0 = 2'd1;
        const1 = 8'h77; regadd1 = 4'hE;
        step();
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_busy", Busy, 1);
        chk("t1_const", CUconst, 8'hA5);
        chk("t1_regadd", RegAdd, 4'h3);
        chk("t1_inssel", InsSel, 2'd1);
        req0 = 0;
        step();
        chk("t1_rel_gnt0", gnt0, 0);
        chk("t1_rel_busy", Busy, 0);
        chk("t1_rel_const", CUconst, 0);
        chk("t1_rel_regadd", RegAdd, 0);
        chk("t1_rel_inssel", InsSel, 0);

        // tie after reset goes to port 0, then back-to-back handover
        reset = 1;
        step();
        reset = 0;
        const1 = 8'h3C; inmux1 = 3'd5; outmux1 = 4'd9; regadd1 = 4'd7; we1 = 1; inssel1 = 2'd2;
        req0 = 1; req1 = 1;
        step();
        chk("t2_gnt0", gnt0, 1);
        chk("t2_gnt1", gnt1, 0);
        req0 = 0;
        step();
        chk("t2_sw_gnt0", gnt0, 0);
        chk("t2_sw_gnt1", gnt1, 1);
        chk("t2_const", CUconst, 8'h3C);
        chk("t2_inmux", InMuxAdd, 3'd5);
        chk("t2_outmux", OutMuxAdd, 4'd9);
        chk("t2_regadd", RegAdd, 4'd7);
        chk("t2_we", WE, 1);
        chk("t2_inssel", InsSel, 2'd2);

        // both held: 4 cycles each, alternating
        reset = 1;
        step();
        reset = 0; req0 = 1; req1 = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("t3_gnt0_c%0d", i), gnt0, ((i / 4) % 2 == 0) ? 1 : 0);
            chk($sformatf("t3_gnt1_c%0d", i), gnt1, ((i / 4) % 2 == 1) ? 1 : 0);
        end

        // port 0 alone is never forced off
        reset = 1;
        step();
        reset = 0; req0 = 1; req1 = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t4_gnt0_c%0d", i), gnt0, 1);
        end
        // late request from port 1 after a saturated hold is served next edge
        req1 = 1;
        step();
        chk("t4_late_gnt1", gnt1, 1);
        req0 = 0; req1 = 0;
        step();
        chk("t4_idle_busy", Busy, 0);

        // write enable gating
        reset = 1;
        step();
        reset = 0; req0 = 1; req1 = 0; we0 = 0; we1 = 1;
        step();
        chk("t5_gnt0", gnt0, 1);
        chk("t5_we_off", WE, 0);
        we0 = 1;
        #1;
        chk("t5_we_on", WE, 1);
        req0 = 0;
        #1;
        chk("t5_we_release", WE, 0);
        chk("t5_gnt0_held", gnt0, 1);
        step();
        chk("t5_gnt0_drop", gnt0, 0);
        we0 = 0;

        // reset during port 1 grant
        req1 = 1; we1 = 1;
        step();
        chk("t6_gnt1", gnt1, 1);
        chk("t6_we", WE, 1);
        reset = 1;
        step();
        chk("t6_rst_gnt1", gnt1, 0);
        chk("t6_rst_we", WE, 0);
        chk("t6_rst_busy", Busy, 0);
        chk("t6_rst_const", CUconst, 0);
        chk("t6_rst_regadd", RegAdd, 0);
        reset = 0; req0 = 1; req1 = 1;
        step();
        chk("t6_tie_gnt0", gnt0, 1);
        chk("t6_tie_gnt1", gnt1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
